// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the execute-stage multiply/divide unit.
// Holds the md_op encodings produced by the D/E decoder and consumed by
// e_mdu, and the default busy latencies for multiply and divide.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage : mdu_pkg

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with architectural HI/LO.
//
// The 64-bit result is computed combinationally in the issue cycle and
// parked in hi_tmp/lo_tmp. A down-counter then models the unit latency,
// and the result is committed to HI/LO on the terminal-count edge.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; accepts mult/div, MTHI, MTLO
// RUN   | counting down; commits hi_tmp/lo_tmp when cnt reaches 1
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (clears HI, LO, cnt, busy)
//   md_op  in   decoded MDU op (mdu_pkg::md_op_e encoding, others = NONE)
//   a, b   in   forwarded rs / rt operands
//   start  out  mult/div accepted this cycle (combinational)
//   busy   out  operation in flight (registered)
//   hi, lo out  architectural HI / LO
//   mduo   out  HI on MFHI, LO on MFLO, else 0 (combinational)
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mduo
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_tmp_q, lo_tmp_q;
  logic        commit_q;

  // Decode
  logic is_mult, is_div, is_signed, is_muldiv;

  always_comb begin
    is_mult   = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (md_op)
      MD_MULT:  begin is_mult = 1'b1; is_signed = 1'b1; end
      MD_MULTU: is_mult = 1'b1;
      MD_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      MD_DIVU:  is_div = 1'b1;
      default:  ;
    endcase
  end

  assign is_muldiv = is_mult | is_div;
  assign start     = is_muldiv & ~busy_q;

  // Result datapath
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_n, div_d;
  logic [31:0] q_u, r_u, q_fix, r_fix;
  logic        div_zero;
  logic [31:0] hi_tmp_d, lo_tmp_d;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes and fixes signs afterwards, which
    // also makes 0x80000000 / -1 wrap to 0x80000000 without relying on
    // simulator/synth handling of signed overflow.
    a_mag = a[31] ? (~a + 32'd1) : a;
    b_mag = b[31] ? (~b + 32'd1) : b;
    div_n = is_signed ? a_mag : a;
    div_d = is_signed ? b_mag : b;

    div_zero = (b == 32'd0);
    q_u = div_zero ? 32'd0 : (div_n / div_d);
    r_u = div_zero ? 32'd0 : (div_n % div_d);

    q_fix = (is_signed && (a[31] ^ b[31])) ? (~q_u + 32'd1) : q_u;
    r_fix = (is_signed && a[31]) ? (~r_u + 32'd1) : r_u;

    if (is_mult) begin
      {hi_tmp_d, lo_tmp_d} = is_signed ? prod_s : prod_u;
    end else begin
      hi_tmp_d = r_fix;
      lo_tmp_d = q_fix;
    end
  end

  // Control FSM and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            // Divide by zero still occupies the unit but leaves HI/LO alone.
            commit_q <= ~(is_div & div_zero);
            cnt_q    <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else if (md_op == MD_MTHI) begin
            hi_q <= a;
          end else if (md_op == MD_MTLO) begin
            lo_q <= a;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - 4'd1;
          // <= guards against a zero-latency parameter wrapping the counter.
          if (cnt_q <= 4'd1) begin
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            if (commit_q) begin
              hi_q <= hi_tmp_q;
              lo_q <= lo_tmp_q;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mduo = 32'd0;
    if (md_op == MD_MFHI) mduo = hi_q;
    else if (md_op == MD_MFLO) mduo = lo_q;
  end

endmodule : e_mdu

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vector table, reset-abort sequence and randomized ops
// checked against an arithmetic model of HI/LO.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] a, b;
  logic        start, busy;
  logic [31:0] hi, lo, mduo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .mduo  (mduo)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      4'd1: begin pu = longint'(unsigned'(sx * sy)); m_hi = pu[63:32]; m_lo = pu[31:0]; end
      4'd2: begin pu = {32'd0, x} * {32'd0, y}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      4'd3: if (y != 0) begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
      4'd4: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      4'd7: m_hi = x;
      4'd8: m_lo = x;
      default: ;
    endcase
  endtask

  // Called just after a negedge; returns just after a negedge with busy low,
  // so consecutive calls exercise back-to-back issue.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    bit is_md;
    int n, cyc;
    is_md = (op >= 4'd1) && (op <= 4'd4);
    n     = (op <= 4'd2) ? MC : DC;
    md_op = op; a = x; b = y;
    #1;
    chk("start", 32'(start), 32'(is_md));
    chk("busy_at_issue", 32'(busy), 32'd0);
    if (op == 4'd5)      chk("mduo_mfhi", mduo, m_hi);
    else if (op == 4'd6) chk("mduo_mflo", mduo, m_lo);
    else                 chk("mduo_zero", mduo, 32'd0);
    model(op, x, y);
    @(negedge clk);
    md_op = MD_NONE; a = $urandom; b = $urandom;
    #1;
    if (is_md) begin
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
        cyc++;
        @(negedge clk);
        #1;
      end
      chk("busy_cycles", 32'(cyc), 32'(n));
    end
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  initial begin
    reset = 1'b1; md_op = MD_NONE; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mduo", mduo, 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    tbl.push_back('{4'd1, 32'hFFFFFFFF, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFE});
    tbl.push_back('{4'd2, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE});
    tbl.push_back('{4'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD});
    tbl.push_back('{4'd4, 32'hFFFFFFF9, 32'd2,          32'h00000001, 32'h7FFFFFFC});
    tbl.push_back('{4'd8, 32'h12345678, 32'd0,          32'h00000001, 32'h12345678});
    tbl.push_back('{4'd3, 32'h00000064, 32'd0,          32'h00000001, 32'h12345678});
    tbl.push_back('{4'd6, 32'h0,        32'd0,          32'h00000001, 32'h12345678});
    tbl.push_back('{4'd3, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000});
    tbl.push_back('{4'd7, 32'hCAFEF00D, 32'd0,          32'hCAFEF00D, 32'h80000000});
    tbl.push_back('{4'd5, 32'h0,        32'd0,          32'hCAFEF00D, 32'h80000000});
    tbl.push_back('{4'd3, 32'd7,        32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD});
    tbl.push_back('{4'd4, 32'd0,        32'd0,          32'h00000001, 32'hFFFFFFFD});
    tbl.push_back('{4'd12, 32'd5,       32'd3,          32'h00000001, 32'hFFFFFFFD});

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].x, tbl[i].y);
      chk("tbl_hi", hi, tbl[i].exp_hi);
      chk("tbl_lo", lo, tbl[i].exp_lo);
    end

    // Reset in the middle of a MULT discards it.
    md_op = MD_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);                      // T+1
    md_op = MD_NONE;
    #1;
    chk("abort_busy_t1", 32'(busy), 32'd1);
    // Asserting MULT while busy must not start anything.
    md_op = MD_MULT;
    #1;
    chk("start_while_busy", 32'(start), 32'd0);
    md_op = MD_NONE;
    @(negedge clk);                      // T+2
    @(negedge clk);                      // T+3
    reset = 1'b1;
    @(negedge clk);                      // T+4
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    issue(MD_MULT, 32'hFFFF0000, 32'h00010001);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 9));
        3: y = -32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(1, 4));
      issue(op, x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_e_mdu
